mpu_matrix_streamer: RTL and testbench
======================================

Name: mpu_matrix_streamer

Overview:
- Output side of the MPU: accepts one flattened 5x5 signed 8-bit result matrix (for example, the output of the opposite/negate operation) in a single parallel beat.
- Streams the matrix out one element per handshake on a byte-wide valid/ready interface toward the host/bus bridge.
- It is the reader/serializer counterpart of the parallel matrix datapath.

Parameters:
- ELEM_W, 8: element width in bits; elements are two's-complement signed.
- DIM, 5: matrix dimension; the matrix holds DIM*DIM elements.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- load_valid  input  1  matrix_in holds a valid matrix.
- load_ready  output  1  streamer can capture a matrix.
- matrix_in  input  DIM*DIM*ELEM_W  flattened matrix. Element k = row + DIM*col occupies bits [ELEM_W*k +: ELEM_W].
- out_valid  output  1  out_data holds an element.
- out_ready  input  1  consumer accepts the element.
- out_data  output  ELEM_W  current element, signed.
- out_col  output  3  col index of the current element.
- out_row  output  3  row index of the current element.
- out_last  output  1  high with element k = DIM*DIM-1.
- busy  output  1  high while in STREAM.

Behaviour:
- Reset state (any cycle rst=1, including mid-stream):
  - state=IDLE, k=0, load_ready=1, out_valid=0, out_data=0, out_col=0, out_row=0, out_last=0, busy=0.
  - The captured matrix register is not cleared; its contents are don't-care.
  - Reset wins over a simultaneous load or out handshake.
- FSM IDLE:
  - load_ready=1, out_valid=0.
  - If load_valid=1 at edge T: register all of matrix_in, set k=0, go to STREAM.
  - out_valid=1 from cycle T+1, so first-element latency is 1 cycle.
- FSM STREAM:
  - load_ready=0; load_valid is ignored and matrix_in may change freely.
  - out_valid=1 continuously; outputs are registered and change only after an accepted beat.
  - out_data = captured element k; out_col = k / DIM; out_row = k % DIM; out_last = (k == DIM*DIM-1).
  - Beat accepted when out_valid & out_ready at a rising edge.
  - Accepted beat with k < DIM*DIM-1: k increments. row counts 0..DIM-1, then wraps to 0 and col increments.
  - Accepted beat with k = DIM*DIM-1: go to IDLE and drop out_valid next cycle. Exactly DIM*DIM beats per matrix; there is no wrap back to k=0 within a stream.
  - out_ready=0: all outputs hold stable indefinitely; there is no timeout.
- Throughput:
  - One element per cycle under continuous out_ready.
  - One mandatory idle cycle between matrices, since load_ready is high only in IDLE.
  - Full matrix occupies 25 STREAM cycles plus 1 IDLE cycle at minimum.
- Arithmetic:
  - No data modification; elements pass bit-exact, sign included.
  - Index counters are held as separate col/row counters (3 bits each, sufficient for DIM≤8); no divider.
- Internal storage is one DIM*DIM*ELEM_W register with an element mux indexed by {col,row}. Shift-register implementation is permitted if outputs are identical.

Optional Feature:
- Macro MPU_STREAMER_ROW_LAST_EN.
- When defined:
  - Adds output port out_row_last (1 bit), high while out_valid and out_row = DIM-1.
  - Resets to 0 and holds under backpressure like the other outputs.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mpu_pkg holds:
  - ELEM_W, DIM, MAT_W = DIM*DIM*ELEM_W;
  - signed element typedef mpu_elem_t and flattened matrix typedef mpu_matrix_t;
  - function elem_index(col,row) = row + DIM*col;
  - FSM state enum {IDLE, STREAM}.
- One sub-module, mpu_elem_mux: combinational selection of element {col,row} from the flattened matrix. It is reusable by a future matrix deserializer.

Test Plan:
- Reset/idle: assert rst 3 cycles then release. Required: load_ready=1, out_valid=0, out_data=0, busy=0.
- Ordered stream: load matrix with element k = k−12 (so k=0 → −12 = 8'hF4, k=24 → +12); hold out_ready=1. Required:
  - out_valid rises 1 cycle after load;
  - 25 consecutive beats in order −12..12, with (col,row) sequence (0,0),(0,1)…(0,4),(1,0)…(4,4);
  - out_last only on beat 25;
  - out_valid=0 and load_ready=1 on the next cycle.
- Backpressure: same matrix; out_ready toggles 1,0,0,1 repeating. Required: every element appears exactly once, stable (data, col, row) while out_ready=0, 25 accepted beats total.
- Load ignored while busy: mid-stream at k=7, pulse load_valid with an all-8'h7F matrix. Required: load_ready=0 and the stream continues from the original matrix (k=8 is −4).
- Reset mid-operation: assert rst at k=10 while out_ready=0. Required: next cycle out_valid=0, load_ready=1. A new load of all-8'h80 then streams 25 beats of −128 starting at (0,0).
- Option: with MPU_STREAMER_ROW_LAST_EN defined, continuous stream. Required: out_row_last high on beats 5,10,15,20,25 only.

Source files
------------

// File: rtl/mpu_matrix_streamer_pkg.sv
// Shared MPU definitions: element/matrix widths, element and matrix types,
// flattened element indexing and the streamer FSM state type.
// Element k = row + DIM*col lives at bits [ELEM_W*k +: ELEM_W] of a matrix.
package mpu_pkg;

  localparam int unsigned ELEM_W = 8;
  localparam int unsigned DIM    = 5;
  localparam int unsigned MAT_N  = DIM * DIM;
  localparam int unsigned MAT_W  = MAT_N * ELEM_W;

  typedef logic signed [ELEM_W-1:0] mpu_elem_t;
  typedef logic        [MAT_W-1:0]  mpu_matrix_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } mpu_state_t;

  function automatic int unsigned elem_index(input logic [2:0] col, input logic [2:0] row);
    return 32'(row) + DIM * 32'(col);
  endfunction

endpackage

// File: rtl/mpu_matrix_streamer_if.sv
// Load/stream handshake bundle of the matrix streamer.
//   load_valid/load_ready/matrix_in : parallel matrix capture handshake
//   out_valid/out_ready/out_data    : byte-wide element stream
//   out_col/out_row/out_last        : position of the current element
// master : producer of the matrix and consumer of the stream
// slave  : the streamer itself
interface mpu_matrix_streamer_if;
  import mpu_pkg::*;

  logic        load_valid;
  logic        load_ready;
  mpu_matrix_t matrix_in;
  logic        out_valid;
  logic        out_ready;
  mpu_elem_t   out_data;
  logic [2:0]  out_col;
  logic [2:0]  out_row;
  logic        out_last;

  modport master (
    output load_valid, matrix_in, out_ready,
    input  load_ready, out_valid, out_data, out_col, out_row, out_last
  );

  modport slave (
    input  load_valid, matrix_in, out_ready,
    output load_ready, out_valid, out_data, out_col, out_row, out_last
  );

endinterface

// File: rtl/mpu_matrix_streamer_elem_mux.sv
// Combinational element selector: returns element {col,row} of a flattened
// DIM x DIM matrix. Out-of-range indices return zero.
//   matrix_i : flattened matrix
//   col_i    : column index
//   row_i    : row index
//   elem_o   : selected signed element
module mpu_elem_mux
  import mpu_pkg::*;
(
  input  mpu_matrix_t matrix_i,
  input  logic [2:0]  col_i,
  input  logic [2:0]  row_i,
  output mpu_elem_t   elem_o
);

  int unsigned idx;

  always_comb begin
    idx    = elem_index(col_i, row_i);
    elem_o = '0;
    for (int unsigned k = 0; k < MAT_N; k++) begin
      if (k == idx) begin
        elem_o = mpu_elem_t'(matrix_i[k*ELEM_W +: ELEM_W]);
      end
    end
  end

endmodule

// File: rtl/mpu_matrix_streamer.sv
// MPU output streamer: captures one flattened DIM x DIM signed matrix in a
// single beat, then emits it one element per valid/ready handshake in
// column-major order (row fastest).
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : load handshake, element stream and element position
//   busy         : high while streaming
//   out_row_last : (only with MPU_STREAMER_ROW_LAST_EN) current element is
//                  the last row of its column
module mpu_matrix_streamer
  import mpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  mpu_matrix_streamer_if.slave  bus,
`ifdef MPU_STREAMER_ROW_LAST_EN
  output logic                  out_row_last,
`endif
  output logic                  busy
);

  localparam logic [2:0] LAST_IDX = 3'(DIM - 1);

  mpu_state_t  state_q, state_d;
  logic [2:0]  col_q, col_d;
  logic [2:0]  row_q, row_d;
  mpu_matrix_t mat_q;
  mpu_elem_t   sel_elem;
  logic        streaming;
  logic        load_fire;
  logic        beat_fire;
  logic        at_last;

  assign streaming = (state_q == STREAM);
  assign load_fire = (state_q == IDLE) && bus.load_valid;
  assign beat_fire = streaming && bus.out_ready;
  assign at_last   = (col_q == LAST_IDX) && (row_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    unique case (state_q)
      IDLE: begin
        if (load_fire) begin
          state_d = STREAM;
          col_d   = '0;
          row_d   = '0;
        end
      end
      STREAM: begin
        if (beat_fire) begin
          if (at_last) begin
            // Indices return to zero so the idle outputs read as (0,0).
            state_d = IDLE;
            col_d   = '0;
            row_d   = '0;
          end else if (row_q == LAST_IDX) begin
            row_d = '0;
            col_d = col_q + 3'd1;
          end else begin
            row_d = row_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Matrix storage is deliberately not reset; it is only read while streaming.
  always_ff @(posedge clk) begin
    if (!rst && load_fire) begin
      mat_q <= bus.matrix_in;
    end
  end

  mpu_elem_mux u_elem_mux (
    .matrix_i (mat_q),
    .col_i    (col_q),
    .row_i    (row_q),
    .elem_o   (sel_elem)
  );

  // All outputs derive only from registered state, so they hold under
  // backpressure and change only after an accepted beat.
  assign bus.load_ready = !streaming;
  assign bus.out_valid  = streaming;
  assign bus.out_data   = streaming ? sel_elem : '0;
  assign bus.out_col    = col_q;
  assign bus.out_row    = row_q;
  assign bus.out_last   = streaming && at_last;
  assign busy           = streaming;

`ifdef MPU_STREAMER_ROW_LAST_EN
  assign out_row_last = streaming && (row_q == LAST_IDX);
`endif

endmodule

// File: tb/tb_mpu_matrix_streamer.sv
// Self-checking bench for mpu_matrix_streamer. Works with or without
// MPU_STREAMER_ROW_LAST_EN defined.
module tb_mpu_matrix_streamer;
  import mpu_pkg::*;

  typedef struct {
    int data;
    int col;
    int row;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
`ifdef MPU_STREAMER_ROW_LAST_EN
  logic out_row_last;
`endif

  mpu_matrix_streamer_if bus ();

  mpu_matrix_streamer dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
`ifdef MPU_STREAMER_ROW_LAST_EN
    .out_row_last (out_row_last),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: element k sits at column k/DIM, row k%DIM; only k=DIM*DIM-1 is last.
  task automatic load_matrix(input int elems[MAT_N]);
    mpu_matrix_t m;
    for (int k = 0; k < int'(MAT_N); k++) begin
      exp_t e;
      m[ELEM_W*k +: ELEM_W] = 8'(elems[k]);
      e.data = elems[k];
      e.col  = k / int'(DIM);
      e.row  = k % int'(DIM);
      e.last = (k == int'(MAT_N) - 1);
      sbq.push_back(e);
    end
    bus.load_valid = 1'b1;
    bus.matrix_in  = m;
    @(posedge clk);
    #1;
    bus.load_valid = 1'b0;
    bus.matrix_in  = {MAT_N{8'($urandom)}};
    @(negedge clk);
    chk("first_latency_valid", int'(bus.out_valid), 1);
    chk("busy_streaming", int'(busy), 1);
  endtask

  task automatic drain(input bit random_ready);
    int budget = 400;
    while (sbq.size() != 0 && budget > 0) begin
      @(posedge clk);
      #1;
      bus.out_ready = random_ready ? ($urandom_range(0, 9) < 7) : 1'b1;
      budget--;
    end
    chk("drain_within_budget", int'(sbq.size()), 0);
    // The cycle after the last accepted beat must be idle.
    @(posedge clk);
    @(negedge clk);
    chk("post_valid", int'(bus.out_valid), 0);
    chk("post_load_ready", int'(bus.load_ready), 1);
  endtask

  // Monitor: pops the scoreboard on each accepted beat; checks holding under stall.
  initial begin : monitor
    bit        stalled = 1'b0;
    mpu_elem_t s_data;
    logic [2:0] s_col, s_row;
    logic      s_last;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && stalled) begin
        chk("stall_hold_data", int'(bus.out_data), int'(s_data));
        chk("stall_hold_col", int'(bus.out_col), int'(s_col));
        chk("stall_hold_row", int'(bus.out_row), int'(s_row));
        chk("stall_hold_last", int'(bus.out_last), int'(s_last));
      end
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("beat_data", int'(bus.out_data), e.data);
          chk("beat_col", int'(bus.out_col), e.col);
          chk("beat_row", int'(bus.out_row), e.row);
          chk("beat_last", int'(bus.out_last), int'(e.last));
`ifdef MPU_STREAMER_ROW_LAST_EN
          chk("beat_row_last", int'(out_row_last), int'(e.row == int'(DIM) - 1));
`endif
        end
      end
      stalled = !rst && bus.out_valid && !bus.out_ready;
      s_data  = bus.out_data;
      s_col   = bus.out_col;
      s_row   = bus.out_row;
      s_last  = bus.out_last;
    end
  end

  initial begin : main
    int ordered[MAT_N];
    int all80[MAT_N];
    int rnd[MAT_N];

    for (int k = 0; k < int'(MAT_N); k++) begin
      ordered[k] = k - 12;
      all80[k]   = -128;
    end

    rst            = 1'b1;
    bus.load_valid = 1'b0;
    bus.matrix_in  = '0;
    bus.out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_load_ready", int'(bus.load_ready), 1);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_out_data", int'(bus.out_data), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_out_col", int'(bus.out_col), 0);
    chk("reset_out_row", int'(bus.out_row), 0);
    chk("reset_out_last", int'(bus.out_last), 0);
`ifdef MPU_STREAMER_ROW_LAST_EN
    chk("reset_row_last", int'(out_row_last), 0);
`endif

    // Ordered stream, continuous ready.
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    load_matrix(ordered);
    drain(1'b0);

    // Backpressure pattern 1,0,0,1.
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    load_matrix(ordered);
    begin
      int budget = 400;
      int cyc = 0;
      while (sbq.size() != 0 && budget > 0) begin
        @(posedge clk);
        #1;
        cyc++;
        bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        budget--;
      end
      chk("backpressure_drain", int'(sbq.size()), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_post_valid", int'(bus.out_valid), 0);

    // Load attempt while streaming at k=7 must be ignored.
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    load_matrix(ordered);
    repeat (7) @(posedge clk);
    #1;
    bus.out_ready  = 1'b0;
    bus.load_valid = 1'b1;
    bus.matrix_in  = {MAT_N{8'h7F}};
    @(negedge clk);
    chk("busy_load_ready", int'(bus.load_ready), 0);
    chk("busy_k7_col", int'(bus.out_col), 1);
    chk("busy_k7_row", int'(bus.out_row), 2);
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    drain(1'b0);

    // Reset mid-stream at k=10 under backpressure.
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    load_matrix(ordered);
    repeat (10) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_load_ready", int'(bus.load_ready), 1);
    chk("midrst_out_col", int'(bus.out_col), 0);
    chk("midrst_out_row", int'(bus.out_row), 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    load_matrix(all80);
    drain(1'b0);

    // Randomized matrices with random ready.
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < int'(MAT_N); k++) begin
        byte b;
        b = byte'($urandom);
        rnd[k] = int'(b);
      end
      @(posedge clk); #1;
      bus.out_ready = $urandom_range(0, 1) == 1;
      load_matrix(rnd);
      drain(1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
